fsm_step_sequencer: RTL and testbench

Programmable stimulus sequencer for the small Moore FSMs in this codebase, which take an `a` bit and a 3-bit `idx` and produce outputs `m`, `n` and `t`. The block holds a short script of `{a, idx}` steps and plays it into the controlled FSM one step per clock. While the script plays, it monitors the FSM's `m`, `n` and `t` outputs and raises a one-cycle `done` when the script ends. It sits between the test/control logic and the FSM instance, and is the only driver of the FSM's `a` and `idx` inputs.

---
 rtl/fsm_step_sequencer_if.sv | 34 +++
 rtl/fsm_step_sequencer.sv | 125 ++++++++++++
 tb/tb_fsm_step_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_step_sequencer_if.sv
// fsm_step_sequencer_if: command/script bus plus the controlled-FSM link
// for fsm_step_sequencer.
// master: control side (also plays the FSM's m/n/t outputs back in).
// slave:  the sequencer itself.
interface fsm_step_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] len;
    logic       start;
    logic       abort;
    logic       loop;
    logic       fsm_m;
    logic       fsm_n;
    logic       fsm_t;
    logic       fsm_a;
    logic [2:0] fsm_idx;
    logic       busy;
    logic       done;
    logic [3:0] t_count;
    logic       mn_hit;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, abort, loop,
        output fsm_m, fsm_n, fsm_t,
        input  fsm_a, fsm_idx, busy, done, t_count, mn_hit
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, abort, loop,
        input  fsm_m, fsm_n, fsm_t,
        output fsm_a, fsm_idx, busy, done, t_count, mn_hit
    );
endinterface

// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer: plays a short script of {a, idx} steps into a small
// Moore FSM, one step per clock, while counting fsm_t cycles and catching
// any fsm_m & fsm_n coincidence. Pulses done on normal completion.
// Optional feature macro: FSM_SEQ_LOOP_EN (replay while loop = 1).
module fsm_step_sequencer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    fsm_step_sequencer_if.slave  bus
);

    localparam logic [3:0] DEPTH_Q = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] len_q;
    logic [3:0] mem [DEPTH];

    logic start_ok;
    logic last_step;
    logic wr_ok;

    // Decode of command acceptance, last step and write permission.
    // A write on the accepting start edge is dropped as if busy were already set.
    always_comb begin
        start_ok  = 1'b0;
        last_step = 1'b0;
        wr_ok     = 1'b0;
        start_ok  = (state == S_IDLE) && bus.start && (bus.len != 4'd0);
        last_step = ({1'b0, ptr} == (len_q - 4'd1));
        wr_ok     = bus.wr_en && !bus.busy && !start_ok
                    && (32'(bus.wr_addr) < DEPTH);
    end

    // Script storage: deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Playback FSM with registered FSM drive, status and monitor outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= S_IDLE;
            ptr         <= '0;
            len_q       <= 4'd1;
            bus.fsm_a   <= 1'b0;
            bus.fsm_idx <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.t_count <= '0;
            bus.mn_hit  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state       <= S_RUN;
                        bus.busy    <= 1'b1;
                        ptr         <= '0;
                        {bus.fsm_a, bus.fsm_idx} <= mem[0];
                        bus.t_count <= '0;
                        bus.mn_hit  <= 1'b0;
                        len_q       <= (bus.len > DEPTH_Q) ? DEPTH_Q : bus.len;
                    end
                end
                S_RUN: begin
                    // Monitors see the FSM state reached by the previous step.
                    if (bus.fsm_t && (bus.t_count != 4'hF)) begin
                        bus.t_count <= bus.t_count + 4'd1;
                    end
                    if (bus.fsm_m && bus.fsm_n) begin
                        bus.mn_hit <= 1'b1;
                    end
                    if (bus.abort) begin
                        state       <= S_IDLE;
                        bus.busy    <= 1'b0;
                        bus.fsm_a   <= 1'b0;
                        bus.fsm_idx <= '0;
                        ptr         <= '0;
                    end else if (last_step) begin
`ifdef FSM_SEQ_LOOP_EN
                        if (bus.loop) begin
                            ptr <= '0;
                            {bus.fsm_a, bus.fsm_idx} <= mem[0];
                        end else begin
                            state       <= S_DONE;
                            bus.busy    <= 1'b0;
                            bus.done    <= 1'b1;
                            bus.fsm_a   <= 1'b0;
                            bus.fsm_idx <= '0;
                            ptr         <= '0;
                        end
`else
                        state       <= S_DONE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.fsm_a   <= 1'b0;
                        bus.fsm_idx <= '0;
                        ptr         <= '0;
`endif
                    end else begin
                        ptr <= ptr + 3'd1;
                        {bus.fsm_a, bus.fsm_idx} <= mem[ptr + 3'd1];
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// tb_fsm_step_sequencer: directed, table-driven bench for fsm_step_sequencer,
// with hand-written sequences for clamp, abort, async reset and looping.
module tb_fsm_step_sequencer;

    logic clk;
    logic rst_b;

    fsm_step_sequencer_if bus ();

    fsm_step_sequencer #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [3:0] wr_data;
        logic [3:0] len;
        logic       start;
        logic       m;
        logic       n;
        logic       t;
        logic       e_a;
        logic [2:0] e_idx;
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_tc;
        logic       e_mn;
    } vec_t;

    vec_t vecs [16];
    logic [3:0] mem_m [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.len     = '0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.loop    = 1'b0;
        bus.fsm_m   = 1'b0;
        bus.fsm_n   = 1'b0;
        bus.fsm_t   = 1'b0;
    endtask

    task automatic write_mem(input int addr, input logic [3:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int k;
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst_b = 1'b0;

        // wr_en wr_addr wr_data len start m n t | a idx busy done tc mn
        vecs[0]  = '{1'b1, 3'd0, 4'h3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 4'h8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 4'h1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 4'hF, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 4'd1, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd2, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd2, 1'b1};
        vecs[7]  = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd2, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 4'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 3'd0, 4'hA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 4'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[15] = '{1'b0, 3'd0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};

        // Reset state, checked while reset is held.
        #3;
        chk("rst_fsm_a",   int'(bus.fsm_a),   0);
        chk("rst_fsm_idx", int'(bus.fsm_idx), 0);
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_done",    int'(bus.done),    0);
        chk("rst_t_count", int'(bus.t_count), 0);
        chk("rst_mn_hit",  int'(bus.mn_hit),  0);
        #9;
        rst_b = 1'b1;
        tick();

        // start with len = 0 is ignored.
        bus.start = 1'b1;
        bus.len   = 4'd0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.start = 1'b0;
            chk("len0_busy", int'(bus.busy), 0);
            chk("len0_done", int'(bus.done), 0);
        end

        // Basic playback, monitoring, same-edge write drop, len = 1.
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.wr_addr = vecs[i].wr_addr;
            bus.wr_data = vecs[i].wr_data;
            bus.len     = vecs[i].len;
            bus.start   = vecs[i].start;
            bus.fsm_m   = vecs[i].m;
            bus.fsm_n   = vecs[i].n;
            bus.fsm_t   = vecs[i].t;
            tick();
            chk($sformatf("vec%0d_fsm_a", i),   int'(bus.fsm_a),   int'(vecs[i].e_a));
            chk($sformatf("vec%0d_fsm_idx", i), int'(bus.fsm_idx), int'(vecs[i].e_idx));
            chk($sformatf("vec%0d_busy", i),    int'(bus.busy),    int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i),    int'(bus.done),    int'(vecs[i].e_done));
            chk($sformatf("vec%0d_t_count", i), int'(bus.t_count), int'(vecs[i].e_tc));
            chk($sformatf("vec%0d_mn_hit", i),  int'(bus.mn_hit),  int'(vecs[i].e_mn));
        end
        idle_inputs();

        // Length clamp: len = 12 plays exactly 8 steps.
        for (int i = 0; i < 8; i++) begin
            mem_m[i] = 4'(((i % 2) * 8) + (7 - i));
            write_mem(i, mem_m[i]);
        end
        bus.len   = 4'd12;
        bus.start = 1'b1;
        busy_cnt  = 0;
        done_cnt  = 0;
        k         = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.busy) begin
                if (k < 8) begin
                    chk($sformatf("clamp_step%0d", k), int'({bus.fsm_a, bus.fsm_idx}), int'(mem_m[k]));
                end
                k++;
                busy_cnt++;
            end
            if (bus.done) done_cnt++;
        end
        chk("clamp_busy_cycles", busy_cnt, 8);
        chk("clamp_done_pulses", done_cnt, 1);

        // Abort while step 2 of 5 is presented.
        bus.len   = 4'd5;
        bus.start = 1'b1;
        tick();                       // E0: step 0
        bus.start = 1'b0;
        bus.fsm_t = 1'b1;
        tick();                       // E1: step 1, t counted
        bus.fsm_t = 1'b0;
        tick();                       // E2: step 2
        chk("abort_pre_idx", int'({bus.fsm_a, bus.fsm_idx}), int'(mem_m[2]));
        bus.abort = 1'b1;
        tick();                       // E3: abort taken
        bus.abort = 1'b0;
        chk("abort_busy",    int'(bus.busy),    0);
        chk("abort_done",    int'(bus.done),    0);
        chk("abort_outputs", int'({bus.fsm_a, bus.fsm_idx}), 0);
        chk("abort_t_count", int'(bus.t_count), 1);
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_t_hold",  int'(bus.t_count), 1);
        chk("abort_busy_after", int'(bus.busy), 0);

        // Asynchronous reset mid-RUN.
        bus.len   = 4'd8;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("rstrun_pre_idx", int'({bus.fsm_a, bus.fsm_idx}), int'(mem_m[1]));
        rst_b = 1'b0;
        #1;
        chk("rstrun_outputs", int'({bus.fsm_a, bus.fsm_idx}), 0);
        chk("rstrun_busy",    int'(bus.busy), 0);
        chk("rstrun_done",    int'(bus.done), 0);
        #2;
        rst_b = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        chk("rstrun_no_done",    done_cnt, 0);
        chk("rstrun_busy_after", int'(bus.busy), 0);

        // Loop request with len = 2.
        write_mem(0, 4'h3);
        write_mem(1, 4'h8);
        bus.loop  = 1'b1;
        bus.len   = 4'd2;
        bus.start = 1'b1;
`ifdef FSM_SEQ_LOOP_EN
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.start = 1'b0;
            chk($sformatf("loop_c%0d_out", c), int'({bus.fsm_a, bus.fsm_idx}), (c % 2 == 0) ? 3 : 8);
            chk($sformatf("loop_c%0d_busy", c), int'(bus.busy), 1);
            chk($sformatf("loop_c%0d_done", c), int'(bus.done), 0);
        end
        bus.loop = 1'b0;
        tick();
        chk("loop_end_done", int'(bus.done), 1);
        chk("loop_end_busy", int'(bus.busy), 0);
        chk("loop_end_out",  int'({bus.fsm_a, bus.fsm_idx}), 0);
`else
        tick();
        bus.start = 1'b0;
        chk("noloop_step0", int'({bus.fsm_a, bus.fsm_idx}), 3);
        tick();
        chk("noloop_step1", int'({bus.fsm_a, bus.fsm_idx}), 8);
        tick();
        chk("noloop_done",  int'(bus.done), 1);
        chk("noloop_busy",  int'(bus.busy), 0);
        chk("noloop_out",   int'({bus.fsm_a, bus.fsm_idx}), 0);
`endif
        bus.loop = 1'b0;
        tick();
        chk("final_done_clear", int'(bus.done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
